clkdiv_multi: RTL and testbench

- Parametrised, multi-channel successor to the fixed 100 ms divider: N_CH independent square-wave dividers off one system clock.
- Each channel has a runtime-programmable half-period, enable, and a one-cycle tick strobe per output period.
- Reconfiguration is glitch-free. Feeds display scan, debounce and counter-step logic that each need different rates from one block.

---
 rtl/clkdiv_multi_if.sv | 25 ++
 rtl/clkdiv_multi.sv | 62 ++++++
 tb/tb_clkdiv_multi.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_multi_if.sv
// Control, configuration and output bundle for the multi-channel clock divider.
// The master side drives enables/config; the slave side (the divider) returns waves and ticks.
interface clkdiv_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int SEL_W = 4
);
  logic [N_CH-1:0]  en;
  logic             clr;
  logic             cfg_we;
  logic [SEL_W-1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_half;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  modport master (
    output en, clr, cfg_we, cfg_sel, cfg_half,
    input  clk_out, tick
  );

  modport slave (
    input  en, clr, cfg_we, cfg_sel, cfg_half,
    output clk_out, tick
  );
endinterface

// File: rtl/clkdiv_multi.sv
// N_CH independent square-wave dividers with runtime-programmable half-periods.
// New half-periods are staged in pending_half and only take effect at a wrap or clr, so outputs never glitch.
module clkdiv_multi #(
  parameter int               N_CH         = 4,
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(5_000_000),
  parameter int               SEL_W        = 4
) (
  input logic          clk,
  input logic          rst_n,
  clkdiv_multi_if.slave bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_half;
    logic [CNT_W-1:0] pending_half;
    logic [CNT_W-1:0] eh;
    logic [CNT_W-1:0] next_pending;
    logic             wr;
    logic             wrap;
    logic             out_r;
    logic             tick_r;

    // A programmed half of zero still has to divide, so it behaves as one.
    assign eh           = (active_half == '0) ? CNT_W'(1) : active_half;
    assign wr           = bus.cfg_we && (bus.cfg_sel == SEL_W'(i));
    assign next_pending = wr ? bus.cfg_half : pending_half;
    assign wrap         = (cnt == eh - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt          <= '0;
        out_r        <= 1'b0;
        tick_r       <= 1'b0;
        active_half  <= DEFAULT_HALF;
        pending_half <= DEFAULT_HALF;
      end else begin
        pending_half <= next_pending;
        tick_r       <= 1'b0;
        if (bus.clr) begin
          cnt         <= '0;
          out_r       <= 1'b0;
          active_half <= next_pending;
        end else if (bus.en[i]) begin
          if (wrap) begin
            cnt         <= '0;
            out_r       <= ~out_r;
            tick_r      <= ~out_r;
            active_half <= next_pending;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end

    assign bus.clk_out[i] = out_r;
    assign bus.tick[i]    = tick_r;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: stimulus queues expected clk_out transitions with their cycle,
// a negedge monitor pops them on every observed transition and also checks tick against each rise.
module tb_clkdiv_multi;
  localparam int N_CH  = 2;
  localparam int CNT_W = 32;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   exp_q [N_CH][$];
  logic [N_CH-1:0] prev = '0;

  clkdiv_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  clkdiv_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_HALF(CNT_W'(3)), .SEL_W(SEL_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input int actual, input int required);
    n_vec = n_vec + 1;
    if (actual != required) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [N_CH-1:0] en, input bit clr, input bit we,
                                input logic [SEL_W-1:0] sel, input int half);
    bus.en       = en;
    bus.clr      = clr;
    bus.cfg_we   = we;
    bus.cfg_sel  = sel;
    bus.cfg_half = CNT_W'(half);
  endtask

  // Expected transition of channel ch to level val, k edges after reset release.
  task automatic expect_edge(input int ch, input int k, input bit val);
    exp_q[ch].push_back((base + k) * 2 + int'(val));
  endtask

  task automatic run_until(input int k);
    while (cyc < base + k) @(negedge clk);
    #1;
  endtask

  // Inputs for the first edge are applied while reset is held, then reset is released mid-cycle.
  task automatic start_phase(input logic [N_CH-1:0] en, input bit clr, input bit we,
                             input logic [SEL_W-1:0] sel, input int half);
    apply_stimulus(en, clr, we, sel, half);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic end_phase(input string name);
    rst_n = 1'b0;
    #1;
    for (int ch = 0; ch < N_CH; ch++) begin
      check_output($sformatf("%s ch%0d missing edges", name, ch), exp_q[ch].size(), 0);
      exp_q[ch].delete();
    end
  endtask

  always @(negedge clk) begin
    int  e;
    bit  changed;
    if (!rst_n) begin
      prev = bus.clk_out;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        changed = (bus.clk_out[ch] != prev[ch]);
        if (changed) begin
          if (exp_q[ch].size() == 0) begin
            check_output($sformatf("ch%0d unexpected edge to %0d at rel cycle", ch, bus.clk_out[ch]),
                         cyc - base, -1);
          end else begin
            e = exp_q[ch].pop_front();
            check_output($sformatf("ch%0d edge rel cycle", ch), cyc - base, e / 2 - base);
            check_output($sformatf("ch%0d edge level", ch), int'(bus.clk_out[ch]), e % 2);
          end
        end
        check_output($sformatf("ch%0d tick at rel cycle %0d", ch, cyc - base),
                     int'(bus.tick[ch]), int'(changed && bus.clk_out[ch]));
      end
      prev = bus.clk_out;
    end
  end

  initial begin
    apply_stimulus(2'b00, 1'b0, 1'b0, 2'd0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("reset clk_out", int'(bus.clk_out), 0);
    check_output("reset tick", int'(bus.tick), 0);

    // Default half of 3: rise 3, fall 6, rise 9 on both channels.
    start_phase(2'b11, 1'b0, 1'b0, 2'd0, 0);
    for (int ch = 0; ch < N_CH; ch++) begin
      expect_edge(ch, 3, 1); expect_edge(ch, 6, 0); expect_edge(ch, 9, 1);
    end
    run_until(9);
    end_phase("basic");

    // Ch0 gets half 5 while cnt=1: current half finishes at 3, then 5-cycle halves.
    start_phase(2'b11, 1'b0, 1'b0, 2'd0, 0);
    expect_edge(0, 3, 1); expect_edge(0, 8, 0); expect_edge(0, 13, 1); expect_edge(0, 18, 0);
    expect_edge(1, 3, 1); expect_edge(1, 6, 0); expect_edge(1, 9, 1);
    expect_edge(1, 12, 0); expect_edge(1, 15, 1); expect_edge(1, 18, 0);
    run_until(1);
    apply_stimulus(2'b11, 1'b0, 1'b1, 2'd0, 5);
    run_until(2);
    apply_stimulus(2'b11, 1'b0, 1'b0, 2'd0, 0);
    run_until(18);
    end_phase("reprogram");

    // Half 0 written together with clr on edge 1: ch0 toggles every edge, ch1 rises 3 after clr.
    start_phase(2'b11, 1'b1, 1'b1, 2'd0, 0);
    for (int k = 2; k <= 10; k++) expect_edge(0, k, (k % 2) == 0);
    expect_edge(1, 4, 1); expect_edge(1, 7, 0); expect_edge(1, 10, 1);
    run_until(1);
    apply_stimulus(2'b11, 1'b0, 1'b0, 2'd0, 0);
    run_until(10);
    end_phase("half0_clr");

    // Ch0 paused for edges 2..11 at cnt=1, half 4 written in the pause.
    start_phase(2'b11, 1'b0, 1'b0, 2'd0, 0);
    expect_edge(0, 13, 1); expect_edge(0, 17, 0); expect_edge(0, 21, 1);
    for (int k = 3; k <= 21; k += 3) expect_edge(1, k, (k % 6) != 0);
    run_until(1);
    apply_stimulus(2'b10, 1'b0, 1'b0, 2'd0, 0);
    run_until(4);
    apply_stimulus(2'b10, 1'b0, 1'b1, 2'd0, 4);
    run_until(5);
    apply_stimulus(2'b10, 1'b0, 1'b0, 2'd0, 0);
    run_until(11);
    apply_stimulus(2'b11, 1'b0, 1'b0, 2'd0, 0);
    run_until(21);
    end_phase("pause");

    // Write to absent channel 3 is ignored; ch1 write landing on its wrap at edge 6 applies at once.
    start_phase(2'b11, 1'b0, 1'b1, 2'd3, 7);
    expect_edge(0, 3, 1); expect_edge(0, 6, 0); expect_edge(0, 9, 1); expect_edge(0, 12, 0);
    expect_edge(1, 3, 1); expect_edge(1, 6, 0); expect_edge(1, 8, 1);
    expect_edge(1, 10, 0); expect_edge(1, 12, 1);
    run_until(1);
    apply_stimulus(2'b11, 1'b0, 1'b0, 2'd0, 0);
    run_until(5);
    apply_stimulus(2'b11, 1'b0, 1'b1, 2'd1, 2);
    run_until(6);
    apply_stimulus(2'b11, 1'b0, 1'b0, 2'd0, 0);
    run_until(12);
    end_phase("sel_wrap");

    // Asynchronous reset while clk_out and tick are high.
    start_phase(2'b11, 1'b0, 1'b0, 2'd0, 0);
    for (int ch = 0; ch < N_CH; ch++) expect_edge(ch, 3, 1);
    run_until(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset clk_out", int'(bus.clk_out), 0);
    check_output("async reset tick", int'(bus.tick), 0);
    end_phase("async_reset");
    start_phase(2'b11, 1'b0, 1'b0, 2'd0, 0);
    for (int ch = 0; ch < N_CH; ch++) begin
      expect_edge(ch, 3, 1); expect_edge(ch, 6, 0); expect_edge(ch, 9, 1);
    end
    run_until(9);
    end_phase("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
